// File: rtl/tt_sweep_pkg.sv
// Shared types and sizes for the truth-table sweeper and its settle timer.
// Rows are 3-bit input patterns; the recovered code holds one bit per row.
package tt_sweep_pkg;

  localparam int TT_ROWS   = 8;
  localparam int TT_IN_W   = 3;
  localparam int TT_CODE_W = 8;

  localparam logic [TT_IN_W-1:0] LAST_ROW = TT_IN_W'(TT_ROWS - 1);

  typedef enum logic {
    IDLE,
    SWEEP
  } sweep_state_e;

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that marks the sample edge of each row.
// It reloads itself on every tick so that consecutive rows are timed back to back.
module sweep_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] count_q;

  // After a load of S the count reaches 1 on the S-th edge, so the tick
  // lands exactly S cycles after the row was first driven.
  assign tick_o = en_i && (count_q == ONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= RELOAD;
    end else if (en_i) begin
      count_q <= tick_o ? RELOAD : count_q - ONE;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all eight rows of a 3-input block, samples its output after a settle
// window per row, and reports the recovered truth-table code against an expectation.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [TT_CODE_W-1:0] expect_code,
  output logic [TT_IN_W-1:0]   dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [TT_CODE_W-1:0] code,
  output logic                 match,
  output logic [TT_CODE_W-1:0] mismatch_mask
);

  if (SETTLE_CYCLES < 1) begin : g_settle_check
    $error("truth_table_sweeper: SETTLE_CYCLES must be at least 1");
  end

  sweep_state_e         state_q;
  logic [TT_IN_W-1:0]   row_q;
  logic                 busy_q;
  logic                 done_q;
  logic [TT_CODE_W-1:0] code_q;
  logic [TT_CODE_W-1:0] code_d;
  logic [TT_CODE_W-1:0] expect_q;
  logic                 match_q;
  logic [TT_CODE_W-1:0] mask_q;

  logic timer_load;
  logic timer_tick;

  // The first SWEEP cycle has busy still low; that cycle launches row 0
  // and arms the settle timer, which is why busy trails acceptance by one edge.
  assign timer_load = (state_q == SWEEP) && !busy_q;

  sweep_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(timer_load),
    .en_i  (busy_q),
    .tick_o(timer_tick)
  );

  // Row 000 lands in the MSB so the code reads left to right in row order.
  always_comb begin
    code_d = code_q;
    code_d[LAST_ROW - row_q] = dut_out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      code_q   <= '0;
      expect_q <= '0;
      match_q  <= 1'b0;
      mask_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= SWEEP;
            expect_q <= expect_code;
            code_q   <= '0;
            match_q  <= 1'b0;
            mask_q   <= '0;
          end
        end
        SWEEP: begin
          if (!busy_q) begin
            busy_q <= 1'b1;
            row_q  <= '0;
          end else if (timer_tick) begin
            code_q <= code_d;
            if (row_q == LAST_ROW) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              row_q   <= '0;
              match_q <= (code_d == expect_q);
              mask_q  <= code_d ^ expect_q;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dut_in        = row_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign code          = code_q;
  assign match         = match_q;
  assign mismatch_mask = mask_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with one S=2 and one S=1 instance,
// each reading a behavioural 3-input block model (combinational or one-cycle delayed).
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start2, start1;
  logic [7:0] exp2, exp1;
  logic [2:0] dutIn2, dutIn1;
  logic       dutOut2, dutOut1;
  logic       busy2, busy1, done2, done1, match2, match1;
  logic [7:0] code2, code1, mask2, mask1;

  logic [7:0] model2Code, model1Code;
  logic       model2Delayed, model1Delayed;
  logic       dly2, dly1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Delayed model: output follows its input pattern one clock later.
  always @(posedge clk) begin
    dly2 <= model2Code[3'd7 - dutIn2];
    dly1 <= model1Code[3'd7 - dutIn1];
  end

  assign dutOut2 = model2Delayed ? dly2 : model2Code[3'd7 - dutIn2];
  assign dutOut1 = model1Delayed ? dly1 : model1Code[3'd7 - dutIn1];

  truth_table_sweeper #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .expect_code(exp2),
    .dut_in(dutIn2), .dut_out(dutOut2), .busy(busy2), .done(done2),
    .code(code2), .match(match2), .mismatch_mask(mask2)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expect_code(exp1),
    .dut_in(dutIn1), .dut_out(dutOut1), .busy(busy1), .done(done1),
    .code(code1), .match(match1), .mismatch_mask(mask1)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // Pulse start across one edge; returns just after the accepting edge (edge 0).
  task automatic applyStimulus(input bit useS1, input logic [7:0] expCode);
    if (useS1) begin
      exp1 = expCode; start1 = 1'b1;
    end else begin
      exp2 = expCode; start2 = 1'b1;
    end
    stepEdge();
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Steps to edge 'lat' after acceptance; done must stay low until then.
  task automatic waitDone(input bit useS1, input int lat, input string tag);
    int early = 0;
    for (int e = 1; e < lat; e++) begin
      stepEdge();
      if (useS1 ? done1 : done2) early++;
    end
    checkOutput({tag, "_early_done"}, 8'(early), 8'd0);
    stepEdge();
    checkOutput({tag, "_done"}, {7'd0, useS1 ? done1 : done2}, 8'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneCount;
    rst_n = 1'b0; start2 = 1'b0; start1 = 1'b0; exp2 = '0; exp1 = '0;
    model2Code = 8'hCD; model1Code = 8'h00; model2Delayed = 1'b0; model1Delayed = 1'b0;
    repeat (3) stepEdge();
    checkOutput("rst_dut_in2", 8'(dutIn2), 8'h00);
    checkOutput("rst_busy2",   8'(busy2),  8'h00);
    checkOutput("rst_done2",   8'(done2),  8'h00);
    checkOutput("rst_code2",   code2,      8'h00);
    checkOutput("rst_match2",  8'(match2), 8'h00);
    checkOutput("rst_mask2",   mask2,      8'h00);
    checkOutput("rst_busy1",   8'(busy1),  8'h00);
    checkOutput("rst_code1",   code1,      8'h00);
    rst_n = 1'b1;
    stepEdge();

    $display("[TB] correct code, S=2");
    applyStimulus(1'b0, 8'hCD);
    checkOutput("t1_busy_e0", 8'(busy2), 8'h00);
    stepEdge();
    checkOutput("t1_busy_e1", 8'(busy2), 8'h01);
    for (int r = 0; r < 8; r++) begin
      checkOutput($sformatf("t1_row%0d", r), 8'(dutIn2), 8'(r));
      stepEdge();
      checkOutput($sformatf("t1_hold%0d", r), 8'(dutIn2), 8'(r));
      checkOutput($sformatf("t1_nodone%0d", r), 8'(done2), 8'h00);
      stepEdge();
    end
    checkOutput("t1_done_e17", 8'(done2), 8'h01);
    checkOutput("t1_busy_e17", 8'(busy2), 8'h00);
    checkOutput("t1_dut_in_e17", 8'(dutIn2), 8'h00);
    checkOutput("t1_code", code2, 8'hCD);
    checkOutput("t1_match", 8'(match2), 8'h01);
    checkOutput("t1_mask", mask2, 8'h00);
    stepEdge();
    checkOutput("t1_done_e18", 8'(done2), 8'h00);
    checkOutput("t1_code_held", code2, 8'hCD);

    $display("[TB] wrong expectation");
    applyStimulus(1'b0, 8'hCC);
    checkOutput("t2_code_clr", code2, 8'h00);
    checkOutput("t2_match_clr", 8'(match2), 8'h00);
    waitDone(1'b0, 17, "t2");
    checkOutput("t2_code", code2, 8'hCD);
    checkOutput("t2_match", 8'(match2), 8'h00);
    checkOutput("t2_mask", mask2, 8'h01);

    $display("[TB] start while busy");
    stepEdge();
    applyStimulus(1'b0, 8'hCD);
    doneCount = 0;
    stepEdge(); stepEdge();
    start2 = 1'b1;
    stepEdge();
    start2 = 1'b0;
    checkOutput("t3_busy_e3", 8'(busy2), 8'h01);
    checkOutput("t3_row_e3", 8'(dutIn2), 8'h01);
    repeat (6) begin
      stepEdge();
      if (done2) doneCount++;
    end
    start2 = 1'b1;
    stepEdge();
    start2 = 1'b0;
    checkOutput("t3_row_e10", 8'(dutIn2), 8'h04);
    repeat (6) begin
      stepEdge();
      if (done2) doneCount++;
    end
    checkOutput("t3_early_done", 8'(doneCount), 8'h00);
    stepEdge();
    checkOutput("t3_done_e17", 8'(done2), 8'h01);
    checkOutput("t3_code", code2, 8'hCD);
    checkOutput("t3_match", 8'(match2), 8'h01);
    repeat (4) begin
      stepEdge();
      if (done2) doneCount++;
    end
    checkOutput("t3_extra_done", 8'(doneCount), 8'h00);
    checkOutput("t3_idle", 8'(busy2), 8'h00);

    $display("[TB] reset mid-sweep");
    applyStimulus(1'b0, 8'hCD);
    repeat (6) stepEdge();
    checkOutput("t4_partial_code", code2, 8'hC0);
    checkOutput("t4_row_e6", 8'(dutIn2), 8'h02);
    rst_n = 1'b0;
    stepEdge();
    rst_n = 1'b1;
    checkOutput("t4_busy", 8'(busy2), 8'h00);
    checkOutput("t4_dut_in", 8'(dutIn2), 8'h00);
    checkOutput("t4_code", code2, 8'h00);
    checkOutput("t4_done", 8'(done2), 8'h00);
    doneCount = 0;
    repeat (15) begin
      stepEdge();
      if (done2) doneCount++;
    end
    checkOutput("t4_no_done", 8'(doneCount), 8'h00);
    checkOutput("t4_still_idle", 8'(busy2), 8'h00);

    $display("[TB] minimum settle, S=1");
    model1Code = 8'h00;
    applyStimulus(1'b1, 8'h00);
    waitDone(1'b1, 9, "t5a");
    checkOutput("t5a_code", code1, 8'h00);
    checkOutput("t5a_match", 8'(match1), 8'h01);
    model1Code = 8'hFF;
    applyStimulus(1'b1, 8'hFF);
    checkOutput("t5b_code_clr", code1, 8'h00);
    checkOutput("t5b_busy_e0", 8'(busy1), 8'h00);
    waitDone(1'b1, 9, "t5b");
    checkOutput("t5b_code", code1, 8'hFF);
    checkOutput("t5b_match", 8'(match1), 8'h01);
    checkOutput("t5b_mask", mask1, 8'h00);

    $display("[TB] settle enforcement with delayed block");
    model2Code = 8'hCD; model2Delayed = 1'b1;
    model1Code = 8'hCD; model1Delayed = 1'b1;
    stepEdge();
    exp1 = 8'hCD; start1 = 1'b1;
    applyStimulus(1'b0, 8'hCD);
    waitDone(1'b0, 17, "t6");
    checkOutput("t6_s2_code", code2, 8'hCD);
    checkOutput("t6_s2_match", 8'(match2), 8'h01);
    checkOutput("t6_s1_code", code1, 8'hE6);
    checkOutput("t6_s1_match", 8'(match1), 8'h00);
    checkOutput("t6_s1_mask", mask1, 8'h2B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential characterizer for 3-input, 1-output combinational logic blocks. It is the reading end of a truth-table module's `{in1, in2, in3}` → `out` interface. On `start` it walks all eight input rows, waits a programmable settle time per row, and samples the block's output. It then reports the recovered 8-bit truth-table code, for example 0xCD, and compares it against an expected code. It sits in the verification/self-test harness next to each generated logic module.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: clock cycles each row is driven before the output is sampled. Legal range is at least 1; an elaboration error is raised for 0.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `start`, input, 1: begin a sweep. Honoured only while idle.
- `expect_code`, input, 8: expected truth-table code. Captured on the accepting `start` edge.
- `dut_in`, output, 3: `{in1, in2, in3}` driven to the block under test. `dut_in[2]` is `in1`.
- `dut_out`, input, 1: the `out` of the block under test.
- `busy`, output, 1: a sweep is in progress.
- `done`, output, 1: one-cycle pulse when a sweep completes.
- `code`, output, 8: recovered truth-table code. Held until the next accepted `start`.
- `match`, output, 1: `code == expect_code_captured`. Valid from `done` onward.
- `mismatch_mask`, output, 8: `code ^ expect_code_captured`. Valid from `done` onward.

## Operation
- **States:**
  - IDLE: `busy=0`. Accepting `start` moves to SWEEP.
  - SWEEP: `busy=1`, row counter r = 0..7, settle counter s = 0..SETTLE_CYCLES-1.
  - From SWEEP, after the 8th sample, the FSM returns to IDLE and pulses `done`.
- **Row order:** `dut_in` = r, ascending 3'b000 to 3'b111.
- **Code bit mapping:** the sample taken for row r is stored in `code[7-r]`. Row 000 is the MSB, so the row list 1,1,0,0,1,1,0,1 yields 0xCD.
- **Start of a sweep:** on the accepting `start` edge, `code` clears to 0x00, and `match` and `mismatch_mask` clear to 0.
- **Completion:** on the final sample edge, `code`, `match` and `mismatch_mask` update together, `dut_in` returns to 000, `busy` falls and `done` rises.
- **`start` while busy:** ignored, with no restart and no error.
- **`start` in the cycle `done` is high:** accepted, because the FSM is already in IDLE.
- **Reset values:** `dut_in=000`, `busy=0`, `done=0`, `code=0x00`, `match=0`, `mismatch_mask=0x00`. The FSM is in IDLE.
- **Reset asserted mid-sweep:** all outputs take their reset values at the next edge. Partial results are discarded and `done` is not pulsed.
- **Sampling:** `dut_out` is sampled as registered at the clock edge. No synchronizer; the block under test shares `clk`.

## Timing
Let S = SETTLE_CYCLES, and let `start` be accepted at edge k.
- Row r is driven on `dut_in` from edge k+1+r·S.
- `dut_out` is sampled at edge k+1+(r+1)·S, the same edge on which row r+1 is driven.
- Each row is stable for exactly S cycles before its sample.
- `busy` is high in the cycles after edges k+1 through k+8S. That is 8S cycles.
- `done` is high for one cycle after edge k+1+8S.
- Start-to-done latency is 8S+1 edges: 17 for S=2, 9 for S=1.
- `busy` is 0 in the cycle after acceptance edge k itself. It rises at k+1 together with row 0.

## Structure
- **Shared package `tt_sweep_pkg`:**
  - state enum `{IDLE, SWEEP}`
  - `TT_ROWS = 8`
  - `TT_IN_W = 3`
  - `TT_CODE_W = 8`
- **Sub-module `sweep_settle_timer`:** loadable down-counter of width `$clog2(SETTLE_CYCLES+1)`. It issues a `tick` on the sample edge and reloads automatically while enabled.
- **Top level** holds the FSM, the row counter, the code shift/insert register and the compare logic.

## Test plan
- **Correct code:** block model 0xCD, S=2, `expect_code`=0xCD, `start` at edge 0 → `dut_in` steps 000..111 every 2 cycles; `done` after edge 17; `code`=0xCD, `match`=1, `mismatch_mask`=0x00.
- **Wrong expectation:** same model, `expect_code`=0xCC → `code`=0xCD, `match`=0, `mismatch_mask`=0x01.
- **Reset mid-sweep:** `rst_n`=0 at edge 7 of a sweep → next edge shows `busy`=0, `dut_in`=000, `code`=0x00; no `done` pulse.
- **`start` while busy:** `start` re-pulsed at edges 3 and 10 → single `done` at edge 17, identical result.
- **Minimum settle:** S=1, constant-0 model → `done` after edge 9, `code`=0x00. Then a constant-1 model with `start` in the `done` cycle → second `done` 9 edges later, `code`=0xFF.
- **Settle enforcement:** model whose output changes one cycle after `dut_in` changes, S=2, true function 0xCD → `code`=0xCD. The same model with S=1 must report a code shifted by one row, showing the sample lands on the edge that follows the S-cycle settle window.
